// File: rtl/gate_sweep_ctrl_if.sv
// gate_sweep_ctrl_if: control, status and gate-under-test signals of the sweep checker
// master: drives start, abort, dut_out; observes stim, busy, done, pass, err_count, fail_vec
// slave:  the sweep controller side
interface gate_sweep_ctrl_if #(parameter int WIDTH = 2);
    logic                  start;
    logic                  abort;
    logic                  dut_out;
    logic [WIDTH-1:0]      stim;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [WIDTH:0]        err_count;
    logic [(1<<WIDTH)-1:0] fail_vec;

    modport master (
        output start, abort, dut_out,
        input  stim, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, abort, dut_out,
        output stim, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: clocked exhaustive sweep of a combinational gate against a truth table
// clk, rst_n (async, active low); bus.slave carries start/abort/dut_out in and
// stim/busy/done/pass/err_count/fail_vec out, all outputs registered
module gate_sweep_ctrl #(
    parameter int                    WIDTH  = 2,
    parameter int                    SETTLE = 2,
    parameter logic [(1<<WIDTH)-1:0] EXPECT = 4'b0110
) (
    input logic              clk,
    input logic              rst_n,
    gate_sweep_ctrl_if.slave bus
);
    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          miss;
    logic [WIDTH:0] errNext;

    assign miss    = bus.dut_out != EXPECT[bus.stim];
    // count including the current sample, so the last pattern is reflected in pass
    assign errNext = bus.err_count + (WIDTH+1)'(miss);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            bus.stim      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.fail_vec  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= WAIT;
                        timer         <= TW'(SETTLE - 1);
                        bus.stim      <= '0;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.pass      <= 1'b0;
                        bus.err_count <= '0;
                        bus.fail_vec  <= '0;
                    end
                end
                WAIT, SAMPLE: begin
                    if (bus.abort) begin
                        // partial results stay visible; an in-flight sample is dropped
                        state    <= IDLE;
                        bus.stim <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b0;
                        bus.pass <= 1'b0;
                    end else if (state == WAIT) begin
                        if (timer == '0)
                            state <= SAMPLE;
                        else
                            timer <= timer - 1'b1;
                    end else begin
                        if (miss) begin
                            bus.fail_vec[bus.stim] <= 1'b1;
                            bus.err_count          <= errNext;
                        end
                        if (bus.stim != {WIDTH{1'b1}}) begin
                            state    <= WAIT;
                            timer    <= TW'(SETTLE - 1);
                            bus.stim <= bus.stim + 1'b1;
                        end else begin
                            state    <= DONE;
                            bus.stim <= '0;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.pass <= errNext == '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed checks of the sweep controller with XOR, stuck-at-0 and AND gate models
module tb_gate_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode = 0;
    int   checks = 0;
    int   errors = 0;

    gate_sweep_ctrl_if #(.WIDTH(2)) bus ();

    gate_sweep_ctrl #(.WIDTH(2), .SETTLE(2), .EXPECT(4'b0110)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // gate models: 0 = XOR, 1 = stuck-at-0, 2 = AND
    assign bus.dut_out = (mode == 0) ? ^bus.stim : (mode == 1) ? 1'b0 : &bus.stim;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startSweep();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic runToDone(input string tag, input int expCycles);
        int n = 0;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        check({tag, "_cycles"}, n, expCycles);
    endtask

    task automatic checkResult(input string tag, input logic p, input logic [2:0] e, input logic [3:0] f);
        check({tag, "_done"}, {31'd0, bus.done}, 1);
        check({tag, "_busy"}, {31'd0, bus.busy}, 0);
        check({tag, "_pass"}, {31'd0, bus.pass}, {31'd0, p});
        check({tag, "_err"}, {29'd0, bus.err_count}, {29'd0, e});
        check({tag, "_fail"}, {28'd0, bus.fail_vec}, {28'd0, f});
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #12;
        check("rst_stim", {30'd0, bus.stim}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_done", {31'd0, bus.done}, 0);
        check("rst_pass", {31'd0, bus.pass}, 0);
        check("rst_err", {29'd0, bus.err_count}, 0);
        check("rst_fail", {28'd0, bus.fail_vec}, 0);
        rst_n = 1'b1;
        step();

        // correct XOR, per-edge stim/busy tracking
        mode = 0;
        startSweep();
        check("xor_busy0", {31'd0, bus.busy}, 1);
        check("xor_stim0", {30'd0, bus.stim}, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("xor_stim_e%0d", k), {30'd0, bus.stim}, (k < 12) ? k / 3 : 0);
            check($sformatf("xor_busy_e%0d", k), {31'd0, bus.busy}, (k < 12) ? 1 : 0);
        end
        checkResult("xor", 1'b1, 3'd0, 4'b0000);
        repeat (3) step();
        checkResult("xor_hold", 1'b1, 3'd0, 4'b0000);

        // stuck-at-0
        mode = 1;
        startSweep();
        check("s0_cleared_pass", {31'd0, bus.pass}, 0);
        runToDone("s0", 12);
        checkResult("s0", 1'b0, 3'd2, 4'b0110);

        // AND against XOR table
        mode = 2;
        startSweep();
        runToDone("and", 12);
        checkResult("and", 1'b0, 3'd3, 4'b1110);

        // start pulsed mid-run is ignored, then restart from DONE with XOR
        mode = 1;
        startSweep();
        repeat (4) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("b2b_busy_mid", {31'd0, bus.busy}, 1);
        runToDone("b2b1", 7);
        checkResult("b2b1", 1'b0, 3'd2, 4'b0110);
        mode = 0;
        startSweep();
        check("b2b2_err_clr", {29'd0, bus.err_count}, 0);
        check("b2b2_fail_clr", {28'd0, bus.fail_vec}, 0);
        runToDone("b2b2", 12);
        checkResult("b2b2", 1'b1, 3'd0, 4'b0000);

        // abort during SAMPLE of pattern 1 with stuck-at-0: that sample is discarded
        mode = 1;
        startSweep();
        repeat (5) step();
        check("ab_stim_pre", {30'd0, bus.stim}, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("ab_busy", {31'd0, bus.busy}, 0);
        check("ab_done", {31'd0, bus.done}, 0);
        check("ab_stim", {30'd0, bus.stim}, 0);
        check("ab_err", {29'd0, bus.err_count}, 0);
        check("ab_fail", {28'd0, bus.fail_vec}, 0);
        repeat (14) step();
        check("ab_idle_done", {31'd0, bus.done}, 0);

        // abort in IDLE is ignored; start wins over simultaneous abort
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("sa_busy", {31'd0, bus.busy}, 1);
        runToDone("sa", 12);
        checkResult("sa", 1'b0, 3'd2, 4'b0110);

        // asynchronous reset mid-WAIT of pattern 2
        mode = 1;
        startSweep();
        repeat (6) step();
        check("ar_stim_pre", {30'd0, bus.stim}, 2);
        #2 rst_n = 1'b0;
        #1;
        check("ar_stim", {30'd0, bus.stim}, 0);
        check("ar_busy", {31'd0, bus.busy}, 0);
        check("ar_done", {31'd0, bus.done}, 0);
        check("ar_err", {29'd0, bus.err_count}, 0);
        check("ar_fail", {28'd0, bus.fail_vec}, 0);
        rst_n = 1'b1;
        step();
        mode = 0;
        startSweep();
        runToDone("ar_after", 12);
        checkResult("ar_after", 1'b1, 3'd0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
